// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the valid/ready memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W   = 32'd32;
  localparam int unsigned DEF_DATA_W   = 32'd32;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Per-transaction stall counter; flags the cycle that exhausts the budget
// and emits a one-cycle timeout pulse on the cycle after.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire,
  output logic timeout_err
);

  localparam int unsigned     CNT_W    = (TIMEOUT == 32'd0) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic             WD_ON    = (TIMEOUT != 32'd0);

  logic [CNT_W-1:0] count_r;
  logic             timeout_err_r;

  // Expiry is the last stalled cycle of the budget, never a cycle with s_ready.
  assign expire      = WD_ON & enable & (count_r == CNT_LAST);
  assign timeout_err = timeout_err_r;

  // Saturating stall counter, restarted whenever the transaction ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r       <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= expire;
      if (clear || expire || !WD_ON) begin
        count_r <= '0;
      end else if (enable && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style valid/ready bus,
// holding the grant for a full transaction with a timeout watchdog.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter int unsigned        DATA_W   = DEF_DATA_W,
  parameter int unsigned        TIMEOUT  = 32'd255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  err_master
);

  arb_state_e state_r;
  logic       last_grant_r;
  logic       err_master_r;

  logic grant0_s;
  logic grant1_s;
  logic gidx_s;
  logic sel_valid_s;
  logic stall_s;
  logic expire_s;
  logic done_s;

  assign grant0_s    = (state_r == GRANT0);
  assign grant1_s    = (state_r == GRANT1);
  assign gidx_s      = grant1_s;
  assign sel_valid_s = grant0_s ? m0_valid : (grant1_s ? m1_valid : 1'b0);
  assign stall_s     = sel_valid_s & ~s_ready;
  // A transaction finishes on slave ready or on a forced timeout completion.
  assign done_s      = sel_valid_s & (s_ready | expire_s);

  assign s_valid = sel_valid_s;
  assign s_addr  = grant0_s ? m0_addr  : (grant1_s ? m1_addr  : '0);
  assign s_wdata = grant0_s ? m0_wdata : (grant1_s ? m1_wdata : '0);
  assign s_wstrb = grant0_s ? m0_wstrb : (grant1_s ? m1_wstrb : '0);

  assign m0_ready = grant0_s & done_s;
  assign m1_ready = grant1_s & done_s;
  assign m0_rdata = grant0_s ? (expire_s ? ERR_DATA : s_rdata) : '0;
  assign m1_rdata = grant1_s ? (expire_s ? ERR_DATA : s_rdata) : '0;

  assign busy       = (state_r != IDLE);
  assign err_master = err_master_r;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .enable      (stall_s),
    .clear       (~stall_s),
    .expire      (expire_s),
    .timeout_err (timeout_err)
  );

  // Grant FSM with round-robin ownership and timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      err_master_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_valid && m1_valid) begin
            state_r <= last_grant_r ? GRANT0 : GRANT1;
          end else if (m0_valid) begin
            state_r <= GRANT0;
          end else if (m1_valid) begin
            state_r <= GRANT1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT0, GRANT1: begin
          if (!sel_valid_s) begin
            // Master withdrew: drop the grant without touching round-robin order.
            state_r <= IDLE;
          end else if (done_s) begin
            state_r      <= IDLE;
            last_grant_r <= gidx_s;
            if (expire_s) begin
              err_master_r <= gidx_s;
            end else begin
              err_master_r <= err_master_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32-style valid/ready memory bus.
- Shares one slave port (work RAM or the chip-select fabric behind it) between the CPU (master 0) and a secondary requester (master 1, e.g. a DMA or GPU fetch engine).
- Arbitration is round-robin; a grant is held for the whole transaction.
- A bus-timeout watchdog completes hung transactions with an error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte strobe width is DATA_W/8.
- TIMEOUT, 255, slave cycles allowed per transaction before forced completion; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_valid  in  1  master 0 request
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; all zero = read
- m0_ready  out  1  master 0 transaction complete
- m0_rdata  out  DATA_W  master 0 read data
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0, for master 1
- s_valid  out  1  slave request
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_ready  in  1  slave complete
- s_rdata  in  DATA_W  slave read data
- busy  out  1  a grant is active
- timeout_err  out  1  one-cycle pulse on forced completion
- err_master  out  1  master index of the last timeout; holds until the next timeout

Behaviour:
- Reset values: state IDLE, last_grant=1 (so m0 wins first), s_valid=0, m0_ready=0, m1_ready=0, busy=0, timeout_err=0, err_master=0, timeout counter=0.
- States: IDLE, GRANT0, GRANT1. Registers: state, last_grant, counter.
- Transitions from IDLE:
  - only m0_valid -> GRANT0.
  - only m1_valid -> GRANT1.
  - both valid -> grant the master not equal to last_grant.
  - neither -> stay IDLE.
- Grant latency: request sampled in IDLE on cycle N; grant state and s_valid on cycle N+1. IDLE never drives s_valid.
- In GRANTx:
  - s_valid = mx_valid; s_addr/s_wdata/s_wstrb = master x fields, combinational.
  - mx_ready = s_ready and mx_rdata = s_rdata, combinational, same cycle.
  - Non-granted master: ready=0, rdata=0.
  - While IDLE, s_addr/s_wdata/s_wstrb = 0.
- Completion (s_ready && s_valid in GRANTx): last_grant<=x, counter<=0, next state IDLE.
  - Back-to-back requests from the same master therefore see one idle cycle.
  - If both masters are waiting, ownership alternates: m0, m1, m0...
- Abort (mx_valid drops while GRANTx, no s_ready): return to IDLE, last_grant unchanged, no ready pulse.
- Timeout (TIMEOUT≠0):
  - counter increments each GRANTx cycle without s_ready.
  - When counter==TIMEOUT-1 and s_ready=0 in the same cycle:
    - force mx_ready=1 and mx_rdata=ERR_DATA.
    - timeout_err pulses on the following cycle; err_master<=x.
    - s_valid is deasserted from the next cycle; next state IDLE; last_grant<=x.
  - s_ready in the same cycle as the timeout wins: normal completion, no error.
- Counter width is clog2(TIMEOUT+1), saturating; it is never allowed to wrap.
- busy = (state != IDLE).
- Reset asserted mid-transaction: next cycle IDLE, all outputs at reset values. An outstanding slave s_ready that arrives later is ignored.
- Writes and reads are treated identically. The arbiter has no address decode; one request is in flight at most.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum (IDLE, GRANT0, GRANT1).
  - DATA_W/ADDR_W default constants.
  - ERR_DATA constant.
- Natural sub-module: bus_watchdog, containing the counter, compare and timeout_err pulse, with enable/clear/expire ports. Everything else sits in mem_arbiter.

Test Plan:
- Single m0 read at 0x1004, slave ready 1 cycle after s_valid with rdata 0x12345678:
  - s_valid rises cycle N+1.
  - m0_ready pulses with m0_rdata=0x12345678.
  - m1_ready stays 0.
- Simultaneous continuous m0/m1 requests after reset:
  - grants m0, m1, m0, m1.
  - each transaction separated by exactly one IDLE cycle.
- m1 write 0x3000, wstrb=4'b0001, wdata=0xA5 while m0 idle:
  - s_wstrb=0001, s_wdata=0xA5, s_addr=0x3000 during GRANT1.
  - m1_ready on the s_ready cycle.
- TIMEOUT=4, slave never ready, m0 read:
  - m0_ready at the 4th grant cycle with rdata=0xDEADBEEF.
  - timeout_err pulse next cycle; err_master=0; state IDLE.
- s_ready arrives on the exact timeout cycle: normal data returned, no timeout_err.
- rst asserted during GRANT1 with the slave stalled:
  - next cycle busy=0, s_valid=0.
  - a later s_ready produces no master ready.
  - the next simultaneous request grants m0.
